// File: rtl/cu_pkg.sv
// Shared types and encodings for the pipelined control unit.
// Control word layout, bubble constant, opcode/funct codes and forward-select values.
package cu_pkg;

    typedef struct packed {
        logic [1:0] branch;
        logic [1:0] ext_sel;
        logic       wr_en;
        logic       opb_sel;
        logic       alu_func;
        logic       wd_sel;
        logic       wm_en;
    } ctrl_t;

    localparam ctrl_t CtrlBubble  = 9'b111100000;
    localparam ctrl_t CtrlIllegal = 9'b000000000;

    localparam int unsigned OpAlu = 0;
    localparam int unsigned OpCmp = 1;
    localparam int unsigned OpLdr = 2;
    localparam int unsigned OpStr = 3;
    localparam int unsigned OpJeq = 4;
    localparam int unsigned OpJne = 5;
    localparam int unsigned OpJmp = 6;
    localparam int unsigned OpNop = 7;

    localparam logic [1:0] FnAdd  = 2'd0;
    localparam logic [1:0] FnAddi = 2'd1;
    localparam logic [1:0] FnSub  = 2'd2;
    localparam logic [1:0] FnSubi = 2'd3;
    localparam logic [1:0] FnCmp  = 2'd2;
    localparam logic [1:0] FnCmpi = 2'd3;

    localparam logic [1:0] FwdNone = 2'b00;
    localparam logic [1:0] FwdMem  = 2'b01;
    localparam logic [1:0] FwdWb   = 2'b10;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode/funct to control-word decoder with source-usage flags.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned FUNCT_W  = 2
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output ctrl_t               ctrl_o,
    output logic                rs1_used_o,
    output logic                rs2_used_o
);

    logic [31:0] op;
    logic [1:0]  fn;

    // Widening lets any opcode above 7 fall through to the illegal default.
    assign op = 32'(opcode_i);
    assign fn = funct_i[1:0];

    always_comb begin
        ctrl_o = CtrlIllegal;
        case (op)
            OpAlu: begin
                case (fn)
                    FnAdd:   ctrl_o = 9'b110010000;
                    FnAddi:  ctrl_o = 9'b110111000;
                    FnSub:   ctrl_o = 9'b110010100;
                    FnSubi:  ctrl_o = 9'b110111100;
                    default: ctrl_o = CtrlIllegal;
                endcase
            end
            OpCmp: begin
                case (fn)
                    FnCmp:   ctrl_o = 9'b110000100;
                    FnCmpi:  ctrl_o = 9'b110101100;
                    default: ctrl_o = CtrlIllegal;
                endcase
            end
            OpLdr:   ctrl_o = 9'b111011010;
            OpStr:   ctrl_o = 9'b111001001;
            OpJeq:   ctrl_o = 9'b001100000;
            OpJne:   ctrl_o = 9'b011100000;
            OpJmp:   ctrl_o = 9'b101100000;
            OpNop:   ctrl_o = CtrlBubble;
            default: ctrl_o = CtrlIllegal;
        endcase
    end

    // rs2 is read for register-operand writers and as store data.
    assign rs1_used_o = (ctrl_o.ext_sel != 2'b11);
    assign rs2_used_o = (~ctrl_o.opb_sel & (ctrl_o.wr_en | ctrl_o.wm_en)) | ctrl_o.wm_en;

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: D-stage decode, E/M/W control slots, RAW stall and branch flush.
// Optional operand forwarding selects and load-use-only stalling under CU_FORWARD_EN.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 3,
    parameter int unsigned FUNCT_W    = 2,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [8:0]            ctrl_e_o,
    output logic [8:0]            ctrl_m_o,
    output logic [8:0]            ctrl_w_o,
    output logic [REG_ADDR_W-1:0] rd_e_o,
    output logic [REG_ADDR_W-1:0] rd_m_o,
    output logic [REG_ADDR_W-1:0] rd_w_o
`ifdef CU_FORWARD_EN
    ,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o
`endif
);

    ctrl_t ctrl_dec;
    logic  rs1_used, rs2_used;

    ctrl_t                 ctrl_e_q, ctrl_m_q, ctrl_w_q;
    logic [REG_ADDR_W-1:0] rd_e_q, rd_m_q, rd_w_q;
    logic                  hazard;
    logic                  src1_e, src2_e;

    cu_decoder #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_decoder (
        .opcode_i   (opcode_i),
        .funct_i    (funct_i),
        .ctrl_o     (ctrl_dec),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign src1_e = rs1_used & ctrl_e_q.wr_en & (rd_e_q == rs1_i);
    assign src2_e = rs2_used & ctrl_e_q.wr_en & (rd_e_q == rs2_i);

`ifdef CU_FORWARD_EN
    logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q;
    logic                  rs1_used_e_q, rs2_used_e_q;

    // Only a load in E cannot be forwarded in time.
    assign hazard = dec_valid_i & ctrl_e_q.wd_sel & (src1_e | src2_e);

    always_comb begin
        fwd_a_o = FwdNone;
        fwd_b_o = FwdNone;
        if (rs1_used_e_q) begin
            if (ctrl_m_q.wr_en && rd_m_q == rs1_e_q)      fwd_a_o = FwdMem;
            else if (ctrl_w_q.wr_en && rd_w_q == rs1_e_q) fwd_a_o = FwdWb;
        end
        if (rs2_used_e_q) begin
            if (ctrl_m_q.wr_en && rd_m_q == rs2_e_q)      fwd_b_o = FwdMem;
            else if (ctrl_w_q.wr_en && rd_w_q == rs2_e_q) fwd_b_o = FwdWb;
        end
    end
`else
    logic src1_m, src2_m;

    assign src1_m = rs1_used & ctrl_m_q.wr_en & (rd_m_q == rs1_i);
    assign src2_m = rs2_used & ctrl_m_q.wr_en & (rd_m_q == rs2_i);
    // W is covered by the write-first register file.
    assign hazard = dec_valid_i & (src1_e | src2_e | src1_m | src2_m);
`endif

    assign stall_o = hazard & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e_q <= CtrlBubble;
            ctrl_m_q <= CtrlBubble;
            ctrl_w_q <= CtrlBubble;
            rd_e_q   <= '0;
            rd_m_q   <= '0;
            rd_w_q   <= '0;
`ifdef CU_FORWARD_EN
            rs1_e_q      <= '0;
            rs2_e_q      <= '0;
            rs1_used_e_q <= 1'b0;
            rs2_used_e_q <= 1'b0;
`endif
        end else begin
            ctrl_w_q <= ctrl_m_q;
            rd_w_q   <= rd_m_q;
            if (flush_i) begin
                ctrl_m_q <= CtrlBubble;
                rd_m_q   <= '0;
            end else begin
                ctrl_m_q <= ctrl_e_q;
                rd_m_q   <= rd_e_q;
            end
            // Flush outranks stall; either way the D instruction does not enter E.
            if (flush_i || hazard || !dec_valid_i) begin
                ctrl_e_q <= CtrlBubble;
                rd_e_q   <= '0;
`ifdef CU_FORWARD_EN
                rs1_e_q      <= '0;
                rs2_e_q      <= '0;
                rs1_used_e_q <= 1'b0;
                rs2_used_e_q <= 1'b0;
`endif
            end else begin
                ctrl_e_q <= ctrl_dec;
                rd_e_q   <= rd_i;
`ifdef CU_FORWARD_EN
                rs1_e_q      <= rs1_i;
                rs2_e_q      <= rs2_i;
                rs1_used_e_q <= rs1_used;
                rs2_used_e_q <= rs2_used;
`endif
            end
        end
    end

    assign ctrl_e_o = ctrl_e_q;
    assign ctrl_m_o = ctrl_m_q;
    assign ctrl_w_o = ctrl_w_q;
    assign rd_e_o   = rd_e_q;
    assign rd_m_o   = rd_m_q;
    assign rd_w_o   = rd_w_q;

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised, pipelined successor to the single-cycle control decoder. Decodes `opcode_i`/`funct_i` in the decode (D) stage and carries the 9-bit control word through registered execute (E), memory (M) and writeback (W) stage slots. Detects read-after-write hazards, stalls D, and kills in-flight instructions on a taken branch. Sits between the fetch/decode register and the datapath stage registers of the pipelined RSA ASIP core.

## Interface
- `OPCODE_W`, default 3: opcode width; codes above 7 decode as illegal.
- `FUNCT_W`, default 2: funct width; only the low 2 bits are decoded.
- `REG_ADDR_W`, default 4: register address width for hazard compare.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid_i` in 1: D holds a valid instruction.
- `opcode_i` in OPCODE_W: D-stage opcode.
- `funct_i` in FUNCT_W: D-stage funct.
- `rd_i`, `rs1_i`, `rs2_i` in REG_ADDR_W each: D-stage destination and source addresses.
- `flush_i` in 1: taken branch resolved in E; kill the D and E instructions.
- `stall_o` out 1: combinational; fetch and D must hold.
- `ctrl_e_o`, `ctrl_m_o`, `ctrl_w_o` out 9 each: registered stage control words.
- `rd_e_o`, `rd_m_o`, `rd_w_o` out REG_ADDR_W each: registered stage destinations.
- `fwd_a_o`, `fwd_b_o` out 2 each: E operand forwarding selects; present only with `CU_FORWARD_EN`.

## Operation
- Control word bit order, MSB to LSB: Branch[1:0], Ext_Sel[1:0], WR_En, Opb_Sel, Alu_Func, WD_Sel, WM_En.
- Decode for op 0, selected by funct: 0 add 110010000; 1 addi 110111000; 2 sub 110010100; 3 subi 110111100.
- Decode for op 1: funct 2 cmp 110000100; funct 3 cmpi 110101100; other funct 000000000.
- Decode for ops 2–7: LDR 111011010; STR 111001001; JEQ 001100000; JNE 011100000; JMP 101100000; NOP 111100000.
- Op ≥ 8: 000000000.
- BUBBLE = 111100000 (NOP encoding, no enables).
- D is treated as BUBBLE when `dec_valid_i`=0, during a stall, or during a flush.
- Source use:
  - rs1 is used unless Ext_Sel=11 (jumps, NOP).
  - rs2 is used when Opb_Sel=0 and WR_En|WM_En, or when WM_En=1 (STR data).
- A stage "writes r" when it has WR_En=1 and its rd=r. Address 0 is compared like any other register.
- Hazard without `CU_FORWARD_EN`: D uses a source that E or M writes. The register file is write-first, so W needs no stall.
- Hazard with `CU_FORWARD_EN`: only load-use, i.e. E has WD_Sel=1 and writes a D source.
- `stall_o` = hazard & ~`flush_i`.
- Stall cycle: E loads BUBBLE; M←E and W←M advance; D holds.
- Flush cycle: E and M load BUBBLE; W←M advances. Flush has priority over stall.
- Forward selects, per E source: 01 if M writes it; else 10 if W writes it; else 00. M has priority over W. An unused source gives 00.

## Timing
- Decode-to-`ctrl_e_o` latency: 1 cycle. Each later stage adds 1 cycle.
- Reset:
  - all ctrl outputs = BUBBLE;
  - all rd outputs = 0;
  - `fwd_*` = 00;
  - `stall_o` = 0 from the cycle after reset.
- Reset mid-stall or mid-flush: the pipeline is fully cleared on that edge, and no pending hazard survives.
- A load-use stall lasts exactly 1 cycle. A non-forwarding RAW on E stalls 2 cycles; a RAW on M only stalls 1 cycle.
- `flush_i` together with a hazard: no stall; the younger instruction is killed.

## Configuration
- `CU_FORWARD_EN` defined:
  - `fwd_a_o`/`fwd_b_o` exist;
  - stall only on load-use.
- `CU_FORWARD_EN` undefined:
  - forward ports absent;
  - E stores no source addresses;
  - stall on any RAW with E or M.

## Structure
- `cu_pkg` holds:
  - the `ctrl_t` packed struct in the field order above;
  - the BUBBLE constant;
  - the opcode and funct localparams;
  - the forward-select encodings.
- Sub-module `cu_decoder`: purely combinational opcode/funct→`ctrl_t`, plus rs1/rs2-used flags.
- The top level holds the stage registers, hazard logic and forward logic.

## Test plan
- Reset then idle: all ctrl outputs = 111100000, rd outputs = 0, `stall_o`=0.
- Back-to-back add r1 → addi r2 → STR → JEQ, independent registers: `ctrl_e_o` = 110010000, 110111000, 111001001, 001100000 on consecutive cycles; same sequence on `ctrl_w_o` 2 cycles later.
- LDR r3 followed by add r4,r3,r5:
  - `stall_o`=1 for 1 cycle with forwarding, then `fwd_a_o`=10;
  - without the macro, 2 stall cycles.
- add r1 then sub r6,r1,r1, forwarding on: no stall; `fwd_a_o`=`fwd_b_o`=01 when sub reaches E.
- Stall coincident with `flush_i`: `stall_o`=0; next cycle `ctrl_e_o`=`ctrl_m_o`=BUBBLE.
- Illegal op 1 funct 0, and `OPCODE_W`=4 with op 9: both give `ctrl_e_o`=000000000 and no hazard.
